// File: rtl/sdram_sched_pkg.sv
// Shared types and constants for the three-port SDRAM scheduler.
// Requester ids double as bit positions in the req/ack masks.
package sdram_sched_pkg;

  localparam int unsigned NUM_REQ = 3;

  typedef enum logic [1:0] {
    REQ_PPU  = 2'd0,
    REQ_CPU  = 2'd1,
    REQ_API  = 2'd2,
    REQ_NONE = 2'd3
  } req_id_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } sched_state_t;

endpackage

// File: rtl/sched_priority_pick.sv
// Combinational arbiter: fixed PPU > CPU > API priority, with a starved API request
// outranking both. The excluded id (the requester just acked) is masked out first.
module sched_priority_pick
  import sdram_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_id_t            exclude,
  input  logic               starve,
  output logic               valid,
  output req_id_t            winner
);

  logic [NUM_REQ-1:0] mask;

  always_comb begin
    // A shift by REQ_NONE falls off the top, so nothing is masked.
    mask   = req & ~(NUM_REQ'(1) << exclude);
    valid  = |mask;
    winner = REQ_NONE;
    if (starve && mask[REQ_API]) begin
      winner = REQ_API;
    end else if (mask[REQ_PPU]) begin
      winner = REQ_PPU;
    end else if (mask[REQ_CPU]) begin
      winner = REQ_CPU;
    end else if (mask[REQ_API]) begin
      winner = REQ_API;
    end
  end

endmodule

// File: rtl/sdram_port_scheduler.sv
// Shares one SDRAM controller port between PPU, CPU and API requesters, one transaction
// at a time, with back-to-back grants straight out of DONE.
module sdram_port_scheduler
  import sdram_sched_pkg::*;
#(
  parameter int unsigned ADDR_BITS    = 23,
  parameter int unsigned DATA_BITS    = 16,
  parameter int unsigned STARVE_LIMIT = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ-1:0]                 we,
  input  logic [NUM_REQ-1:0][ADDR_BITS-1:0]  addr,
  input  logic [NUM_REQ-1:0][DATA_BITS-1:0]  wdata,
  output logic [NUM_REQ-1:0]                 ack,
  output logic [DATA_BITS-1:0]               rdata,
  output logic                               ram_req,
  output logic                               ram_we,
  output logic [ADDR_BITS-1:0]               ram_addr,
  output logic [DATA_BITS-1:0]               ram_wdata,
  input  logic                               ram_ack,
  input  logic [DATA_BITS-1:0]               ram_rdata,
  output logic [1:0]                         grant_id,
  output logic                               busy
);

  localparam int unsigned AgeBits = $clog2(STARVE_LIMIT + 1);

  sched_state_t       state;
  logic [AgeBits-1:0] api_age;
  logic               starve;
  req_id_t            exclude;
  logic               pick_valid;
  req_id_t            winner;
  logic               api_grant;

  assign starve    = (api_age == AgeBits'(STARVE_LIMIT));
  assign exclude   = (state == DONE) ? req_id_t'(grant_id) : REQ_NONE;
  assign api_grant = pick_valid && (winner == REQ_API) && (state == IDLE || state == DONE);

  sched_priority_pick u_pick (
    .req     (req),
    .exclude (exclude),
    .starve  (starve),
    .valid   (pick_valid),
    .winner  (winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      api_age   <= '0;
      ack       <= '0;
      rdata     <= '0;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      grant_id  <= REQ_NONE;
      busy      <= 1'b0;
    end else begin
      ack <= '0;

      if (!req[REQ_API] || api_grant) begin
        api_age <= '0;
      end else if (!starve) begin
        api_age <= api_age + 1'b1;
      end

      case (state)
        IDLE, DONE: begin
          if (pick_valid) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            ram_req   <= 1'b1;
            ram_we    <= we[winner];
            ram_addr  <= addr[winner];
            ram_wdata <= wdata[winner];
            grant_id  <= winner;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (ram_ack) begin
            state   <= DONE;
            busy    <= 1'b0;
            ram_req <= 1'b0;
            rdata   <= ram_rdata;
            ack     <= NUM_REQ'(1) << grant_id;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_scheduler.sv
// Directed bench for sdram_port_scheduler with a hand-driven one-cycle controller.
module tb_sdram_port_scheduler;
  import sdram_sched_pkg::*;

  localparam int unsigned AB = 23;
  localparam int unsigned DB = 16;

  logic                       clk;
  logic                       rst;
  logic [2:0]                 req;
  logic [2:0]                 we;
  logic [2:0][AB-1:0]         addr;
  logic [2:0][DB-1:0]         wdata;
  logic [2:0]                 ack;
  logic [DB-1:0]              rdata;
  logic                       ram_req;
  logic                       ram_we;
  logic [AB-1:0]              ram_addr;
  logic [DB-1:0]              ram_wdata;
  logic                       ram_ack;
  logic [DB-1:0]              ram_rdata;
  logic [1:0]                 grant_id;
  logic                       busy;

  int checks = 0;
  int errors = 0;

  sdram_port_scheduler #(
    .ADDR_BITS    (AB),
    .DATA_BITS    (DB),
    .STARVE_LIMIT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .ack       (ack),
    .rdata     (rdata),
    .ram_req   (ram_req),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_ack   (ram_ack),
    .ram_rdata (ram_rdata),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled and inputs changed 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; ram_ack = 1'b0; ram_rdata = '0;
    tick();
    tick();
    checks++; if (ack !== 3'b000) begin errors++; $display("FAIL rst_ack got %b want 000", ack); end
    checks++; if (ram_req !== 1'b0) begin errors++; $display("FAIL rst_ram_req got %b want 0", ram_req); end
    checks++; if (ram_we !== 1'b0 || ram_addr !== '0 || ram_wdata !== '0) begin
      errors++; $display("FAIL rst_ram_bus got we=%b a=%h d=%h want 0", ram_we, ram_addr, ram_wdata);
    end
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL rst_rdata got %h want 0000", rdata); end
    checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL rst_grant got %0d want 3", grant_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (dut.api_age !== 3'd0) begin errors++; $display("FAIL rst_age got %0d want 0", dut.api_age); end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    req = 3'b010; we = 3'b000; addr[1] = 23'h1234;
    tick();
    checks++; if (ram_req !== 1'b1 || ram_addr !== 23'h1234 || ram_we !== 1'b0) begin
      errors++; $display("FAIL rd_issue got req=%b a=%h we=%b want 1 001234 0", ram_req, ram_addr, ram_we);
    end
    checks++; if (grant_id !== 2'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL rd_grant got id=%0d busy=%b want 1 1", grant_id, busy);
    end
    ram_ack = 1'b1; ram_rdata = 16'hBEEF;
    tick();
    checks++; if (ack !== 3'b010 || rdata !== 16'hBEEF) begin
      errors++; $display("FAIL rd_ack got ack=%b rdata=%h want 010 beef", ack, rdata);
    end
    checks++; if (ram_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rd_release got req=%b busy=%b want 0 0", ram_req, busy);
    end
    ram_ack = 1'b0; req = 3'b000;
    tick();
    checks++; if (ack !== 3'b000 || ram_req !== 1'b0) begin
      errors++; $display("FAIL rd_idle got ack=%b req=%b want 000 0", ack, ram_req);
    end
  endtask

  task automatic test_contention();
    req = 3'b011; we = 3'b000; addr[0] = 23'h000100; addr[1] = 23'h000200;
    tick();
    checks++; if (grant_id !== 2'd0 || ram_addr !== 23'h000100) begin
      errors++; $display("FAIL ct_first got id=%0d a=%h want 0 000100", grant_id, ram_addr);
    end
    ram_ack = 1'b1; ram_rdata = 16'h1111;
    tick();
    checks++; if (ack !== 3'b001 || rdata !== 16'h1111) begin
      errors++; $display("FAIL ct_ack0 got ack=%b rdata=%h want 001 1111", ack, rdata);
    end
    ram_ack = 1'b0;
    tick();
    // Straight from DONE into ISSUE for the CPU.
    checks++; if (grant_id !== 2'd1 || busy !== 1'b1 || ram_req !== 1'b1 || ram_addr !== 23'h000200) begin
      errors++; $display("FAIL ct_b2b got id=%0d busy=%b req=%b a=%h want 1 1 1 000200",
                         grant_id, busy, ram_req, ram_addr);
    end
    req = 3'b010; ram_ack = 1'b1; ram_rdata = 16'h2222;
    tick();
    checks++; if (ack !== 3'b010 || rdata !== 16'h2222) begin
      errors++; $display("FAIL ct_ack1 got ack=%b rdata=%h want 010 2222", ack, rdata);
    end
    req = 3'b000; ram_ack = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    req = 3'b111; we = 3'b000;
    tick();
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL st_g0 got %0d want 0", grant_id); end
    ram_ack = 1'b1;
    tick();
    ram_ack = 1'b0;
    tick();
    checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL st_g1 got %0d want 1", grant_id); end
    ram_ack = 1'b1;
    tick();
    ram_ack = 1'b0;
    checks++; if (dut.api_age !== 3'd4) begin errors++; $display("FAIL st_age4 got %0d want 4", dut.api_age); end
    tick();
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL st_api got %0d want 2", grant_id); end
    checks++; if (dut.api_age !== 3'd0) begin errors++; $display("FAIL st_age0 got %0d want 0", dut.api_age); end
    ram_ack = 1'b1;
    tick();
    checks++; if (ack !== 3'b100) begin errors++; $display("FAIL st_ack got %b want 100", ack); end
    req = 3'b000; ram_ack = 1'b0;
    tick();
  endtask

  task automatic test_api_write();
    req = 3'b100; we = 3'b100; addr[2] = 23'h7FFFFF; wdata[2] = 16'h00FF;
    tick();
    addr[2] = 23'h000055; wdata[2] = 16'hAAAA;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ram_req !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 23'h7FFFFF ||
                    ram_wdata !== 16'h00FF || ack !== 3'b000) begin
        errors++; $display("FAIL wr_hold%0d got req=%b we=%b a=%h d=%h ack=%b want 1 1 7fffff 00ff 000",
                           i, ram_req, ram_we, ram_addr, ram_wdata, ack);
      end
      tick();
    end
    ram_ack = 1'b1; ram_rdata = 16'h5A5A;
    tick();
    checks++; if (ack !== 3'b100) begin errors++; $display("FAIL wr_ack got %b want 100", ack); end
    req = 3'b000; we = 3'b000; ram_ack = 1'b0;
    tick();
    checks++; if (ack !== 3'b000) begin errors++; $display("FAIL wr_single got %b want 000", ack); end
  endtask

  task automatic test_spurious_ack();
    ram_ack = 1'b1; ram_rdata = 16'hDEAD;
    tick();
    ram_ack = 1'b0;
    checks++; if (ack !== 3'b000 || rdata !== 16'h5A5A) begin
      errors++; $display("FAIL sp_ack got ack=%b rdata=%h want 000 5a5a", ack, rdata);
    end
    checks++; if (dut.state !== IDLE || busy !== 1'b0 || ram_req !== 1'b0) begin
      errors++; $display("FAIL sp_state got st=%0d busy=%b req=%b want 0 0 0", dut.state, busy, ram_req);
    end
  endtask

  task automatic test_reset_in_issue();
    req = 3'b010; we = 3'b000; addr[1] = 23'h000777;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ri_busy got %b want 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 3'b000;
    checks++; if (ram_req !== 1'b0 || ack !== 3'b000 || grant_id !== 2'd3) begin
      errors++; $display("FAIL ri_reset got req=%b ack=%b id=%0d want 0 000 3", ram_req, ack, grant_id);
    end
    ram_ack = 1'b1; ram_rdata = 16'h1357;
    tick();
    ram_ack = 1'b0;
    checks++; if (ack !== 3'b000 || busy !== 1'b0 || rdata !== 16'h0000) begin
      errors++; $display("FAIL ri_late got ack=%b busy=%b rdata=%h want 000 0 0000", ack, busy, rdata);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_starvation();
    test_api_write();
    test_spurious_ack();
    test_reset_in_issue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
